// File: rtl/sram_test_sequencer_if.sv
// Single-outstanding-request memory port between the SRAM test sequencer
// (master) and the SRAM controller front end (slave).
interface sram_test_sequencer_if #(
    parameter int ADDR_BITS = 20,
    parameter int DATA_BITS = 16
);
    logic                 mem_valid;
    logic                 mem_write;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [DATA_BITS-1:0] mem_wdata;
    logic                 mem_ready;
    logic                 mem_rvalid;
    logic [DATA_BITS-1:0] mem_rdata;

    modport master (
        output mem_valid, mem_write, mem_addr, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_write, mem_addr, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/sram_test_sequencer.sv
// Steps a pattern generator through its list; for each pattern writes every
// SRAM address, reads it all back and reports pass or the first mismatch.
module sram_test_sequencer #(
    parameter int                   ADDR_BITS = 20,
    parameter int                   DATA_BITS = 16,
    parameter logic [ADDR_BITS-1:0] LAST_ADDR = {ADDR_BITS{1'b1}}
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  gen_reset,
    output logic                  gen_next,
    input  logic [DATA_BITS-1:0]  gen_pattern,
    input  logic                  gen_done,
    sram_test_sequencer_if.master mem,
    output logic                  busy,
    output logic                  pass,
    output logic                  fail,
    output logic [ADDR_BITS-1:0]  fail_addr,
    output logic [DATA_BITS-1:0]  fail_expected,
    output logic [DATA_BITS-1:0]  fail_actual
);

    typedef enum logic [3:0] {
        IDLE, GEN_RST, SETTLE, WRITE, READ, WAIT_R, ADVANCE, PASS, FAIL
    } state_t;

    state_t               state_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [DATA_BITS-1:0] expected_q;
    logic                 gen_reset_q, gen_next_q;
    logic                 mem_valid_q, mem_write_q;
    logic                 busy_q, pass_q, fail_q;
    logic [ADDR_BITS-1:0] fail_addr_q;
    logic [DATA_BITS-1:0] fail_expected_q, fail_actual_q;

    // addr_q and expected_q double as the request address and write data,
    // so the request fields cannot move while a request is stalled.
    assign mem.mem_valid  = mem_valid_q;
    assign mem.mem_write  = mem_write_q;
    assign mem.mem_addr   = addr_q;
    assign mem.mem_wdata  = expected_q;
    assign gen_reset      = gen_reset_q;
    assign gen_next       = gen_next_q;
    assign busy           = busy_q;
    assign pass           = pass_q;
    assign fail           = fail_q;
    assign fail_addr      = fail_addr_q;
    assign fail_expected  = fail_expected_q;
    assign fail_actual    = fail_actual_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            expected_q      <= '0;
            gen_reset_q     <= 1'b0;
            gen_next_q      <= 1'b0;
            mem_valid_q     <= 1'b0;
            mem_write_q     <= 1'b0;
            busy_q          <= 1'b0;
            pass_q          <= 1'b0;
            fail_q          <= 1'b0;
            fail_addr_q     <= '0;
            fail_expected_q <= '0;
            fail_actual_q   <= '0;
        end else begin
            case (state_q)
                IDLE, PASS, FAIL: begin
                    if (start) begin
                        pass_q          <= 1'b0;
                        fail_q          <= 1'b0;
                        fail_addr_q     <= '0;
                        fail_expected_q <= '0;
                        fail_actual_q   <= '0;
                        gen_reset_q     <= 1'b1;
                        busy_q          <= 1'b1;
                        state_q         <= GEN_RST;
                    end
                end
                GEN_RST: begin
                    gen_reset_q <= 1'b0;
                    state_q     <= SETTLE;
                end
                SETTLE: begin
                    if (gen_done) begin
                        pass_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= PASS;
                    end else begin
                        expected_q  <= gen_pattern;
                        addr_q      <= '0;
                        mem_valid_q <= 1'b1;
                        mem_write_q <= 1'b1;
                        state_q     <= WRITE;
                    end
                end
                WRITE: begin
                    if (mem.mem_ready) begin
                        if (addr_q == LAST_ADDR) begin
                            addr_q      <= '0;
                            mem_write_q <= 1'b0;
                            state_q     <= READ;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                        end
                    end
                end
                READ: begin
                    if (mem.mem_ready) begin
                        mem_valid_q <= 1'b0;
                        state_q     <= WAIT_R;
                    end
                end
                WAIT_R: begin
                    if (mem.mem_rvalid) begin
                        if (mem.mem_rdata != expected_q) begin
                            fail_q          <= 1'b1;
                            fail_addr_q     <= addr_q;
                            fail_expected_q <= expected_q;
                            fail_actual_q   <= mem.mem_rdata;
                            busy_q          <= 1'b0;
                            state_q         <= FAIL;
                        end else if (addr_q == LAST_ADDR) begin
                            gen_next_q <= 1'b1;
                            state_q    <= ADVANCE;
                        end else begin
                            addr_q      <= addr_q + 1'b1;
                            mem_valid_q <= 1'b1;
                            state_q     <= READ;
                        end
                    end
                end
                ADVANCE: begin
                    gen_next_q <= 1'b0;
                    state_q    <= SETTLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_test_sequencer.sv
// Directed bench: behavioural 7-pattern generator and 4-word memory model
// with optional backpressure, stuck bit and long read latency.
module tb_sram_test_sequencer;
    localparam int AB = 2;
    localparam int DB = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          gen_reset, gen_next, gen_done;
    logic [DB-1:0] gen_pattern;
    logic          busy, pass, fail;
    logic [AB-1:0] fail_addr;
    logic [DB-1:0] fail_expected, fail_actual;

    sram_test_sequencer_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) mif ();

    sram_test_sequencer #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
        .clk(clk), .reset(reset), .start(start),
        .gen_reset(gen_reset), .gen_next(gen_next),
        .gen_pattern(gen_pattern), .gen_done(gen_done),
        .mem(mif.master),
        .busy(busy), .pass(pass), .fail(fail),
        .fail_addr(fail_addr), .fail_expected(fail_expected),
        .fail_actual(fail_actual)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    logic [DB-1:0] pats [7] = '{16'h0000, 16'hFFFF, 16'hAAAA, 16'h5555,
                                16'h0001, 16'h8000, 16'h1234};
    logic [DB-1:0] mem_arr [4];
    int            gidx = 0;
    int            n_grst = 0, n_gnext = 0, n_wr = 0, n_rd = 0;
    int            rd_cnt = 0;
    logic [AB-1:0] rd_addr;
    bit            bp = 0, stuck = 0;
    int            lat_fix = 1;
    bit            stall_prev = 0;
    logic          prev_w;
    logic [AB-1:0] prev_a;
    logic [DB-1:0] prev_d;

    // Generator and memory respond at the falling edge.
    always @(negedge clk) begin
        if (gen_reset) begin
            gidx = 0;
            n_grst++;
        end else if (gen_next) begin
            gidx++;
            n_gnext++;
        end
        gen_done    = (gidx >= 7);
        gen_pattern = gen_done ? 16'h0 : pats[gidx];

        if (stall_prev && !reset)
            check("stall_hold",
                  32'({mif.mem_valid, mif.mem_write, mif.mem_addr, mif.mem_wdata}),
                  32'({1'b1, prev_w, prev_a, prev_d}));

        mif.mem_rvalid = 1'b0;
        if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
                mif.mem_rvalid = 1'b1;
                mif.mem_rdata  = mem_arr[rd_addr] | ((stuck && rd_addr == 2'd2) ? 16'h0001 : 16'h0000);
            end
        end

        mif.mem_ready = bp ? ($urandom_range(0, 99) < 30) : 1'b1;
        if (mif.mem_valid && mif.mem_ready && !reset) begin
            if (mif.mem_write) begin
                mem_arr[mif.mem_addr] = mif.mem_wdata;
                n_wr++;
            end else begin
                rd_cnt  = bp ? int'($urandom_range(1, 5)) : lat_fix;
                rd_addr = mif.mem_addr;
                n_rd++;
            end
        end
        stall_prev = mif.mem_valid && !mif.mem_ready && !reset;
        prev_w = mif.mem_write;
        prev_a = mif.mem_addr;
        prev_d = mif.mem_wdata;
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max);
        bit done = 0;
        for (int i = 0; i < max; i++) begin
            if (!busy) begin
                done = 1;
                break;
            end
            @(negedge clk);
        end
        if (!done) check("timeout", 32'(busy), 32'(0));
    endtask

    function automatic logic [31:0] outs_ctl();
        return 32'({busy, pass, fail, gen_reset, gen_next, mif.mem_valid, mif.mem_write});
    endfunction

    int b_grst, b_gnext, b_wr, b_rd;

    task automatic snap();
        b_grst = n_grst; b_gnext = n_gnext; b_wr = n_wr; b_rd = n_rd;
    endtask

    task automatic check_clean(input string tag);
        check({tag, "_pass"},   32'(pass), 32'(1));
        check({tag, "_fail"},   32'(fail), 32'(0));
        check({tag, "_busy"},   32'(busy), 32'(0));
        check({tag, "_gnext"},  n_gnext - b_gnext, 7);
        check({tag, "_grst"},   n_grst - b_grst, 1);
        check({tag, "_writes"}, n_wr - b_wr, 28);
        check({tag, "_reads"},  n_rd - b_rd, 28);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) mem_arr[i] = 16'h0;
        reset = 1'b1;
        start = 1'b0;
        mif.mem_ready  = 1'b0;
        mif.mem_rvalid = 1'b0;
        mif.mem_rdata  = 16'h0;
        gen_done    = 1'b0;
        gen_pattern = 16'h0;
        repeat (3) @(negedge clk);
        check("rst_ctl", outs_ctl(), 32'(0));
        check("rst_fail_data", 32'({fail_addr, fail_expected, fail_actual}), 32'(0));
        check("rst_mem_data", 32'({mif.mem_addr, mif.mem_wdata}), 32'(0));
        reset = 1'b0;

        // Clean pass
        snap();
        pulse_start();
        check("start_grst", 32'(gen_reset), 32'(1));
        check("start_busy", 32'(busy), 32'(1));
        wait_done(3000);
        check_clean("clean");

        // Stuck bit at address 2
        stuck = 1;
        snap();
        pulse_start();
        wait_done(3000);
        check("stuck_fail",  32'(fail), 32'(1));
        check("stuck_pass",  32'(pass), 32'(0));
        check("stuck_addr",  32'(fail_addr), 32'(2));
        check("stuck_exp",   32'(fail_expected), 32'(16'h0000));
        check("stuck_act",   32'(fail_actual), 32'(16'h0001));
        check("stuck_gnext", n_gnext - b_gnext, 0);
        check("stuck_reads", n_rd - b_rd, 3);

        // Restart after fail with the memory fixed
        stuck = 0;
        snap();
        pulse_start();
        check("restart_clr", 32'({fail, fail_addr, fail_actual, fail_expected}), 32'(0));
        wait_done(3000);
        check_clean("restart");

        // Backpressure and variable read latency
        bp = 1;
        snap();
        pulse_start();
        wait_done(8000);
        check_clean("bp");
        bp = 0;

        // Start while busy in the write sweep
        snap();
        pulse_start();
        for (int i = 0; i < 100 && (n_wr - b_wr) < 2; i++) @(negedge clk);
        check("busy_in_write", 32'({busy, mif.mem_write}), 32'(2'b11));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(3000);
        check_clean("busy_start");

        // Reset while a read is outstanding
        lat_fix = 4;
        snap();
        pulse_start();
        for (int i = 0; i < 200 && rd_cnt == 0; i++) @(negedge clk);
        @(negedge clk);
        check("rd_outstanding", 32'(rd_cnt > 0), 32'(1));
        #1 reset = 1'b1;
        #1;
        check("rst_mid_ctl", outs_ctl(), 32'(0));
        check("rst_mid_data", 32'({fail_addr, fail_expected, fail_actual}), 32'(0));
        repeat (6) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_mid_hold", outs_ctl(), 32'(0));
        lat_fix = 1;
        snap();
        pulse_start();
        wait_done(3000);
        check_clean("after_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/sram_test_sequencer.md
# sram_test_sequencer

Controller for the SRAM test: sequences an external pattern generator through its pattern list and, for each pattern, writes it to every SRAM address, then reads back and compares each word. Drives the generator's `next`/`reset` inputs and a single-outstanding-request memory port in front of the SRAM controller. Reports pass, or the first failing address with expected and actual data.

## Interface
- `ADDR_BITS`, 20, memory address width
- `DATA_BITS`, 16, memory and pattern data width
- `LAST_ADDR`, all ones (`{ADDR_BITS{1'b1}}`), last address swept; the sweep covers 0..LAST_ADDR inclusive

- `clk`  in  1  system clock
- `reset`  in  1  reset, asynchronous, active-high
- `start`  in  1  begin a test; single-cycle pulse; ignored while `busy`
- `gen_reset`  out  1  generator reset, one-cycle pulse
- `gen_next`  out  1  generator advance, one-cycle pulse (generator steps on its rising edge)
- `gen_pattern`  in  DATA_BITS  current pattern from the generator
- `gen_done`  in  1  generator has stepped past its final pattern
- `mem_valid`  out  1  request valid; held until accepted
- `mem_write`  out  1  1 = write, 0 = read; stable while `mem_valid`
- `mem_addr`  out  ADDR_BITS  request address
- `mem_wdata`  out  DATA_BITS  write data (equals latched pattern)
- `mem_ready`  in  1  request accepted when `mem_valid && mem_ready`
- `mem_rvalid`  in  1  read data valid, one cycle, one per accepted read
- `mem_rdata`  in  DATA_BITS  read data
- `busy`  out  1  test in progress
- `pass`  out  1  sticky; all patterns verified
- `fail`  out  1  sticky; mismatch found
- `fail_addr`  out  ADDR_BITS  address of first mismatch
- `fail_expected`  out  DATA_BITS  pattern expected at `fail_addr`
- `fail_actual`  out  DATA_BITS  data read at `fail_addr`

## Operation
- States: IDLE, GEN_RST, SETTLE, WRITE, READ, WAIT_R, ADVANCE, PASS, FAIL.
- IDLE/PASS/FAIL + `start`: clear `pass`, `fail`, and the `fail_*` outputs. Pulse `gen_reset`, then go to GEN_RST.
- GEN_RST: one cycle, then SETTLE.
- SETTLE: one cycle for the generator outputs to settle.
  - `gen_done`=1 → PASS.
  - Otherwise latch `gen_pattern` into `expected`, set addr=0, go to WRITE.
- WRITE: assert `mem_valid`, `mem_write`=1, `mem_wdata`=`expected`.
  - On accept with addr==LAST_ADDR: addr=0, go to READ.
  - On any other accept: addr+1.
- READ: assert `mem_valid`, `mem_write`=0. On accept, go to WAIT_R with `mem_valid` deasserted.
- WAIT_R: wait for `mem_rvalid`.
  - `mem_rdata`≠`expected`: capture `fail_addr`=addr, `fail_expected`, `fail_actual`; go to FAIL.
  - Match with addr==LAST_ADDR: go to ADVANCE.
  - Other match: addr+1, go to READ.
- ADVANCE: pulse `gen_next` for one cycle, then go to SETTLE.
- PASS/FAIL: `busy`=0; the flag holds until the next `start` or `reset`.
- `busy`=1 in every state except IDLE, PASS and FAIL.
- `start` while `busy`: ignored.
- Address arithmetic is ADDR_BITS wide. Termination compares against LAST_ADDR, so the address never wraps past LAST_ADDR.
- Comparison covers the full DATA_BITS width; there is no masking.

## Timing
- Reset values: all outputs 0; state=IDLE; addr=0; `expected`=0.
- Reset mid-test: `mem_valid` and `gen_*` drop asynchronously. Any read still outstanding is discarded; an `mem_rvalid` in IDLE is ignored.
- `start`→`gen_reset` high: next cycle. `gen_reset`, `gen_next` and `mem_*` are all registered outputs.
- One memory request is outstanding at a time. After a write is accepted, the next request may issue on the following cycle.
- `mem_valid`, `mem_write`, `mem_addr` and `mem_wdata` stay constant while `mem_valid && !mem_ready`.
- `mem_rvalid` is tolerated any number of cycles ≥1 after the read is accepted.
- `gen_next` is a 1-cycle pulse. `gen_pattern`/`gen_done` are sampled 2 cycles after the pulse rises (ADVANCE → SETTLE → sample at end of SETTLE).
- `pass`/`fail` assert in the cycle after the decision and are mutually exclusive.

## Test plan
- **Clean pass:** ADDR_BITS=2, 7-pattern generator, ideal memory with `mem_ready`=1 and rvalid 1 cycle later. Required: 7 write sweeps and 7 read sweeps of addrs 0..3, exactly 7 `gen_next` pulses, then `pass`=1, `busy`=0.
- **Stuck bit:** memory forces bit0=1 at addr 2. Required: `fail`=1, `fail_addr`=2, `fail_expected`=0x0000, `fail_actual`=0x0001, during the first read sweep; no further `gen_next`.
- **Backpressure:** `mem_ready` random at 30% and rvalid latency 1–5 cycles. Required: same result as the clean pass; the request fields are stable while stalled (checked by assertion).
- **Start while busy:** `start` pulsed in the middle of the WRITE sweep. Required: no `gen_reset` pulse and no effect on the sequence.
- **Reset mid-read:** assert `reset` while a read is outstanding, then deliver `mem_rvalid`. Required: all outputs are 0 immediately and stay 0; a subsequent `start` runs to `pass`.
- **Restart after fail:** `start` in FAIL with the memory fixed. Required: `fail`, `fail_addr`, `fail_expected` and `fail_actual` clear on `start`, and the run ends in `pass`=1.
